rx_write_sequencer: RTL and testbench
=====================================

# rx_write_sequencer

Write-side controller for the RX sample FIFO, in the `wr_clk` (RX) domain between the DDC channel outputs and the dual-clock FIFO write port. On each accepted `rxstrobe` inside an external gate window it writes one complete sample set (`ch_0` … `ch_{channels-1}`) as consecutive 16-bit words. The first set of each gate window is preceded by a two-word header. It refuses any set that cannot be written whole, and reports refused sets with a sticky overflow flag.

## Interface
- `FIFO_DEPTH`, 4096: FIFO depth in words.
- `HEADROOM`, 16: minimum free words required to accept a set (≥ 10 = 2 header + 8 channels).
- `SYNC_WORD`, 16'hFFFF: first header word.
- `clock` in 1: RX clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `rxstrobe` in 1: decimated sample strobe, one-cycle pulse.
- `gate_enable` in 1: external gate; sets are accepted only while it is high.
- `channels` in 4: active channel count; 0 = write nothing; values 9–15 are treated as 8.
- `ch_0` … `ch_7` in 16 each: channel samples, valid in the `rxstrobe` cycle.
- `wr_usedw` in 12: FIFO write-side fill level.
- `clear_status` in 1: clears `overflow`.
- `wr_req` out 1: FIFO write enable.
- `wr_data` out 16: FIFO write data, aligned with `wr_req`.
- `overflow` out 1: sticky; at least one set was dropped.
- `busy` out 1: high while a set is being written.
- `gate_count` out 16: number of headers emitted; wraps.

## Operation
- Reset: state IDLE. `wr_req`, `wr_data`, `overflow`, `busy`, `gate_count`, the capture registers, `gate_d` and `hdr_pend` are all 0.
- `gate_d` is `gate_enable` registered.
- `hdr_pend` is set when `gate_enable & ~gate_d`. It is cleared when header word 2 is written, or when `gate_enable` is low.
- Acceptance condition, evaluated at each edge:
  - `rxstrobe & gate_enable & (channels != 0)`
  - state == IDLE
  - `wr_usedw <= FIFO_DEPTH - HEADROOM`
- On acceptance:
  - Capture `ch_0..ch_7` and the effective count `n` = min(`channels`, 8).
  - Go to HDR_SYNC if `hdr_pend`, otherwise to DATA with word index 0.
- HDR_SYNC: write `SYNC_WORD`, go to HDR_CNT.
- HDR_CNT: write the current `gate_count`, increment `gate_count` (16'hFFFF → 0), clear `hdr_pend`, go to DATA.
- DATA: write `ch_<idx>`, then idx+1. After idx = n-1, return to IDLE.
- Drop: if `rxstrobe & gate_enable & (channels != 0)` but the set is not accepted (state ≠ IDLE or insufficient space):
  - Set `overflow`.
  - Write nothing and leave `hdr_pend` unchanged, so the header moves to the next accepted set.
- Ignore rules:
  - `rxstrobe` with `gate_enable` low: ignored, no overflow.
  - `rxstrobe` with `channels == 0`: ignored, no overflow.
- `overflow`: set has priority over `clear_status` in the same cycle. `clear_status` alone clears it on the next edge.
- Gate falling mid-set: the set completes whole. No set is ever truncated.
- `channels` changing mid-set: no effect on the set in progress (`n` is latched).
- `ch_*` changing after the strobe cycle: no effect (samples are latched).
- `wr_usedw` is checked only at acceptance. HEADROOM guarantees the FIFO cannot fill mid-set.

## Timing
- Strobe accepted at edge E0. `wr_req` = 1 for exactly W consecutive cycles starting after E0, where W = n, or n+2 with a header.
- `wr_data` is registered and changes only together with `wr_req`. It holds its last value when `wr_req` = 0.
- `busy` = 1 exactly while `wr_req` = 1.
- The next strobe can be accepted at edge E0+W+1 (state back in IDLE). A strobe at any edge E0+1 … E0+W is dropped.
- `overflow` rises on the edge after the dropped-strobe cycle.
- `gate_count` updates on the edge that ends the HDR_CNT write.
- `gate_rise` to header: the header is emitted with the first set accepted at or after the edge following the gate rise. A strobe in the same cycle as the gate rising edge gets the header.
- Asynchronous `reset` mid-set: `wr_req` drops immediately, the partial set is abandoned, and all state returns to reset values.

## Test plan
- `channels`=4, `ch_0..3`=1,2,3,4, gate rises, then one strobe → six words FFFF, 0000, 0001, 0002, 0003, 0004 on six consecutive cycles starting the cycle after the strobe; `gate_count`=1.
- Second strobe in the same gate, 64 cycles later → four words 1,2,3,4 with no header; `gate_count` stays 1.
- Strobe 3 cycles after an accepted 4-channel set → dropped, `overflow`=1 and stays 1; `clear_status` pulse → 0. Simultaneous drop and `clear_status` → `overflow`=1.
- `wr_usedw`=4081 at a strobe → no writes, `overflow`=1. `wr_usedw`=4080 → set written.
- Gate toggled three times with a strobe in each window; strobes with gate low; `channels`=0 strobe → headers carry counts 0, 1, 2. Gate-low and `channels`=0 strobes produce no writes and no overflow.
- `channels`=8, gate falls during word 3 → all 10 words written. `reset` asserted during word 5 of another set → `wr_req` low immediately and `gate_count`=0 afterwards.

Source files
------------

// File: rtl/rx_write_sequencer.sv
// ============================================================================
// Module   : rx_write_sequencer
// Purpose  : RX-domain FIFO write controller; writes whole sample sets with a
//            two-word header on the first set of each gate window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rx_write_sequencer #(
  parameter int          FIFO_DEPTH = 4096,
  parameter int          HEADROOM   = 16,
  parameter logic [15:0] SYNC_WORD  = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rxstrobe,
  input  logic        gate_enable,
  input  logic [3:0]  channels,
  input  logic [15:0] ch_0,
  input  logic [15:0] ch_1,
  input  logic [15:0] ch_2,
  input  logic [15:0] ch_3,
  input  logic [15:0] ch_4,
  input  logic [15:0] ch_5,
  input  logic [15:0] ch_6,
  input  logic [15:0] ch_7,
  input  logic [11:0] wr_usedw,
  input  logic        clear_status,
  output logic        wr_req,
  output logic [15:0] wr_data,
  output logic        overflow,
  output logic        busy,
  output logic [15:0] gate_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HDR_SYNC = 2'd1,
    S_HDR_CNT  = 2'd2,
    S_DATA     = 2'd3
  } state_t;

  localparam logic [12:0] FILL_LIMIT = 13'(FIFO_DEPTH - HEADROOM);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  n_q, n_d;
  logic [15:0] cap_q [8];
  logic [15:0] cap_d [8];
  logic [15:0] ch_in [8];
  logic        wr_req_q, wr_req_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        overflow_q, overflow_d;
  logic [15:0] gate_count_q, gate_count_d;
  logic        gate_dly_q;
  logic        hdr_pend_q, hdr_pend_d;

  logic        strobe_hit;
  logic        gate_rise;
  logic        room_ok;
  logic        accept;
  logic [3:0]  n_eff;
  logic [2:0]  idx_nxt;

  always_comb begin
    ch_in[0] = ch_0;
    ch_in[1] = ch_1;
    ch_in[2] = ch_2;
    ch_in[3] = ch_3;
    ch_in[4] = ch_4;
    ch_in[5] = ch_5;
    ch_in[6] = ch_6;
    ch_in[7] = ch_7;
  end

  assign strobe_hit = rxstrobe & gate_enable & (channels != 4'd0);
  assign gate_rise  = gate_enable & ~gate_dly_q;
  assign room_ok    = ({1'b0, wr_usedw} <= FILL_LIMIT);
  assign accept     = strobe_hit & (state_q == S_IDLE) & room_ok;
  assign n_eff      = (channels > 4'd8) ? 4'd8 : channels;
  assign idx_nxt    = idx_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_d          = n_q;
    cap_d        = cap_q;
    wr_req_d     = 1'b0;
    wr_data_d    = wr_data_q;
    gate_count_d = gate_count_q;
    hdr_pend_d   = hdr_pend_q;
    overflow_d   = overflow_q;

    // A refused set always flags, even if clear_status is asserted alongside.
    if (strobe_hit && !accept) begin
      overflow_d = 1'b1;
    end else if (clear_status) begin
      overflow_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cap_d    = ch_in;
          n_d      = n_eff;
          idx_d    = 3'd0;
          wr_req_d = 1'b1;
          // A strobe coinciding with the gate rise already belongs to the new window.
          if (hdr_pend_q || gate_rise) begin
            state_d   = S_HDR_SYNC;
            wr_data_d = SYNC_WORD;
          end else begin
            state_d   = S_DATA;
            wr_data_d = ch_0;
          end
        end
      end
      S_HDR_SYNC: begin
        wr_req_d  = 1'b1;
        wr_data_d = gate_count_q;
        state_d   = S_HDR_CNT;
      end
      S_HDR_CNT: begin
        wr_req_d     = 1'b1;
        wr_data_d    = cap_q[0];
        gate_count_d = gate_count_q + 16'd1;
        idx_d        = 3'd0;
        state_d      = S_DATA;
      end
      S_DATA: begin
        if ({1'b0, idx_q} == (n_q - 4'd1)) begin
          state_d = S_IDLE;
        end else begin
          idx_d     = idx_nxt;
          wr_req_d  = 1'b1;
          wr_data_d = cap_q[idx_nxt];
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!gate_enable) begin
      hdr_pend_d = 1'b0;
    end else if (gate_rise) begin
      hdr_pend_d = 1'b1;
    end else if (state_q == S_HDR_CNT) begin
      hdr_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      n_q          <= 4'd0;
      for (int i = 0; i < 8; i++) cap_q[i] <= 16'd0;
      wr_req_q     <= 1'b0;
      wr_data_q    <= 16'd0;
      overflow_q   <= 1'b0;
      gate_count_q <= 16'd0;
      gate_dly_q   <= 1'b0;
      hdr_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      cap_q        <= cap_d;
      wr_req_q     <= wr_req_d;
      wr_data_q    <= wr_data_d;
      overflow_q   <= overflow_d;
      gate_count_q <= gate_count_d;
      gate_dly_q   <= gate_enable;
      hdr_pend_q   <= hdr_pend_d;
    end
  end

  assign wr_req     = wr_req_q;
  assign wr_data    = wr_data_q;
  assign busy       = wr_req_q;
  assign overflow   = overflow_q;
  assign gate_count = gate_count_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_write_sequencer.sv
// ============================================================================
// Module   : tb_rx_write_sequencer
// Purpose  : Scoreboard bench for rx_write_sequencer: expected words with their
//            cycle stamps are queued at each strobe and matched by a monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rx_write_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rxstrobe = 1'b0;
  logic        gate_enable = 1'b0;
  logic [3:0]  channels = 4'd4;
  logic [15:0] ch_v [8];
  logic [11:0] wr_usedw = 12'd0;
  logic        clear_status = 1'b0;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        overflow;
  logic        busy;
  logic [15:0] gate_count;

  typedef struct {
    logic [15:0] d;
    int          cy;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  rx_write_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .rxstrobe     (rxstrobe),
    .gate_enable  (gate_enable),
    .channels     (channels),
    .ch_0         (ch_v[0]),
    .ch_1         (ch_v[1]),
    .ch_2         (ch_v[2]),
    .ch_3         (ch_v[3]),
    .ch_4         (ch_v[4]),
    .ch_5         (ch_v[5]),
    .ch_6         (ch_v[6]),
    .ch_7         (ch_v[7]),
    .wr_usedw     (wr_usedw),
    .clear_status (clear_status),
    .wr_req       (wr_req),
    .wr_data      (wr_data),
    .overflow     (overflow),
    .busy         (busy),
    .gate_count   (gate_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_ch(input logic [15:0] base);
    for (int i = 0; i < 8; i++) ch_v[i] = base + 16'(i);
  endtask

  task automatic push(input logic [15:0] d, input int cy);
    exp_t e;
    e.d  = d;
    e.cy = cy;
    sb.push_back(e);
  endtask

  // Accepted strobe: word k of the set is expected on cycle (strobe cycle + 1 + k).
  task automatic send(input bit hdr, input logic [15:0] cnt, input int n);
    int c;
    c = cyc;
    if (hdr) begin
      push(16'hFFFF, c + 1);
      push(cnt, c + 2);
      c = c + 2;
    end
    for (int i = 0; i < n; i++) push(ch_v[i], c + 1 + i);
    rxstrobe = 1'b1;
    @(negedge clock);
    rxstrobe = 1'b0;
  endtask

  task automatic pulse();
    rxstrobe = 1'b1;
    @(negedge clock);
    rxstrobe = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && wr_req) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got data %h with no expected word (cycle %0d)", wr_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_word{cycle,data}", {cyc[15:0], wr_data}, {e.cy[15:0], e.d});
        chk("busy_during_write", {31'd0, busy}, 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    set_ch(16'h0001);
    tick(2);
    chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gate_count", {16'd0, gate_count}, 32'd0);
    reset = 1'b0;
    tick(2);

    // First set of a window: header + 4 channels.
    gate_enable = 1'b1;
    tick(1);
    send(1'b1, 16'h0000, 4);
    tick(8);
    chk("gc_after_first", {16'd0, gate_count}, 32'd1);
    chk("sb_empty_1", 32'(sb.size()), 32'd0);

    // Second set in the same window, no header.
    tick(55);
    send(1'b0, 16'h0000, 4);
    tick(8);
    chk("gc_same_window", {16'd0, gate_count}, 32'd1);
    chk("ovf_clean", {31'd0, overflow}, 32'd0);

    // Drop 3 cycles after an accepted set; inputs changed after the strobe.
    send(1'b0, 16'h0000, 4);
    for (int i = 0; i < 8; i++) ch_v[i] = 16'hDEA0 + 16'(i);
    channels = 4'd8;
    tick(2);
    pulse();
    chk("ovf_after_drop", {31'd0, overflow}, 32'd1);
    set_ch(16'h0001);
    channels = 4'd4;
    tick(6);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Drop and clear together: set wins.
    tick(2);
    send(1'b0, 16'h0000, 4);
    clear_status = 1'b1;
    pulse();
    clear_status = 1'b0;
    chk("ovf_drop_beats_clear", {31'd0, overflow}, 32'd1);
    tick(6);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    chk("ovf_cleared_2", {31'd0, overflow}, 32'd0);

    // Fill-level boundary.
    wr_usedw = 12'd4081;
    pulse();
    chk("ovf_usedw_4081", {31'd0, overflow}, 32'd1);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    wr_usedw = 12'd4080;
    send(1'b0, 16'h0000, 4);
    wr_usedw = 12'd0;
    tick(6);
    chk("ovf_usedw_4080", {31'd0, overflow}, 32'd0);
    chk("sb_empty_2", 32'(sb.size()), 32'd0);

    // Fresh reset, then three gate windows.
    gate_enable = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("gc_after_reset", {16'd0, gate_count}, 32'd0);

    channels = 4'd2;
    set_ch(16'h0A00);
    gate_enable = 1'b1;
    send(1'b1, 16'h0000, 2);
    tick(4);
    gate_enable = 1'b0;
    tick(2);
    pulse();
    tick(2);

    gate_enable = 1'b1;
    tick(3);
    channels = 4'd0;
    pulse();
    tick(1);
    channels = 4'd12;
    set_ch(16'h0B00);
    send(1'b1, 16'h0001, 8);
    tick(12);
    gate_enable = 1'b0;
    tick(2);
    chk("ovf_ignored_strobes", {31'd0, overflow}, 32'd0);
    chk("sb_empty_3", 32'(sb.size()), 32'd0);

    gate_enable = 1'b1;
    tick(1);
    channels = 4'd1;
    set_ch(16'h0C00);
    wr_usedw = 12'd4095;
    pulse();
    chk("ovf_full_in_window", {31'd0, overflow}, 32'd1);
    wr_usedw = 12'd0;
    tick(1);
    send(1'b1, 16'h0002, 1);
    tick(5);
    chk("gc_three_windows", {16'd0, gate_count}, 32'd3);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    gate_enable = 1'b0;
    tick(2);

    // Gate falls during word 3 of an 8-channel set.
    gate_enable = 1'b1;
    tick(1);
    channels = 4'd8;
    set_ch(16'h2000);
    send(1'b1, 16'h0003, 8);
    tick(2);
    gate_enable = 1'b0;
    tick(12);
    chk("gc_gate_fall", {16'd0, gate_count}, 32'd4);
    chk("sb_empty_4", 32'(sb.size()), 32'd0);

    // Asynchronous reset during word 5.
    gate_enable = 1'b1;
    tick(1);
    set_ch(16'h3000);
    send(1'b1, 16'h0004, 8);
    tick(4);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_wr_req", {31'd0, wr_req}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_words_left", 32'(sb.size()), 32'd5);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    gate_enable = 1'b0;
    chk("rst_mid_gate_count", {16'd0, gate_count}, 32'd0);
    chk("rst_mid_overflow", {31'd0, overflow}, 32'd0);
    tick(5);
    chk("sb_empty_final", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
